// File: rtl/pad_input_filter_pkg.sv
// ============================================================================
// pad_input_filter_pkg : shared types for the pad input filter
// Rev 1.0
// ============================================================================
`default_nettype none

package pad_input_filter_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    BOTH = 2'd3
  } edge_sel_e;

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } filter_state_e;

endpackage

`default_nettype wire

// File: rtl/pad_input_sync.sv
// ============================================================================
// pad_input_sync : multi-flop synchronizer for one asynchronous bit
// Rev 1.0
// ============================================================================
`default_nettype none

module pad_input_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pad_input_filter.sv
// ============================================================================
// pad_input_filter : synchronize, deglitch and edge-detect one pad input
// Rev 1.0
// ============================================================================
`default_nettype none

module pad_input_filter
  import pad_input_filter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pad_i,
  input  logic                 enable_i,
  input  logic [CNT_WIDTH-1:0] filter_len_i,
  input  edge_sel_e            edge_sel_i,
  input  logic                 event_clr_i,
  output logic                 value_o,
  output logic                 edge_pulse_o,
  output logic                 event_o
);

  logic                 sync_q;
  filter_state_e        state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 differ;
  logic                 commit;
  logic                 dir_match;

  pad_input_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (pad_i),
    .sync_o  (sync_q)
  );

  // A commit's direction is the new level, i.e. sync_q itself.
  always_comb begin
    differ = (sync_q != value_o);
    commit = 1'b0;
    if (enable_i && differ) begin
      if (state == STABLE) commit = (filter_len_i == '0);
      else                 commit = (cnt >= filter_len_i);
    end
    dir_match = 1'b0;
    case (edge_sel_i)
      RISE:    dir_match = sync_q;
      FALL:    dir_match = ~sync_q;
      BOTH:    dir_match = 1'b1;
      default: dir_match = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= STABLE;
      cnt          <= '0;
      value_o      <= RESET_VALUE;
      edge_pulse_o <= 1'b0;
      event_o      <= 1'b0;
    end else begin
      if (!enable_i) begin
        state <= STABLE;
        cnt   <= '0;
      end else begin
        case (state)
          STABLE: begin
            if (differ && (filter_len_i != '0)) begin
              state <= QUALIFY;
              cnt   <= CNT_WIDTH'(1);
            end else begin
              cnt <= '0;
            end
          end
          QUALIFY: begin
            if (!differ || commit) begin
              state <= STABLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
          default: begin
            state <= STABLE;
            cnt   <= '0;
          end
        endcase
      end

      if (commit) value_o <= sync_q;
      edge_pulse_o <= commit;

      // Set beats clear when both land in the same cycle.
      if (commit && dir_match) event_o <= 1'b1;
      else if (event_clr_i)    event_o <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pad_input_filter.sv
// ============================================================================
// tb_pad_input_filter : randomized bench with a run-length reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pad_input_filter;
  import pad_input_filter_pkg::*;

  localparam int SYNC = 2;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pad = 1'b0;
  logic          enable = 1'b0;
  logic          event_clr = 1'b0;
  logic [CW-1:0] filter_len = '0;
  edge_sel_e     edge_sel = NONE;
  logic          value, pulse, event_flag;

  always #5 clk = ~clk;

  pad_input_filter #(
    .SYNC_STAGES (SYNC),
    .CNT_WIDTH   (CW),
    .RESET_VALUE (1'b0)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pad_i        (pad),
    .enable_i     (enable),
    .filter_len_i (filter_len),
    .edge_sel_i   (edge_sel),
    .event_clr_i  (event_clr),
    .value_o      (value),
    .edge_pulse_o (pulse),
    .event_o      (event_flag)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pad history gives the synchronized level; a commit
  // happens once the level has differed for N+1 consecutive enabled cycles.
  logic m_value, m_pulse, m_event, m_s, m_hit;
  int   m_run;
  logic hist[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_value = 1'b0; m_pulse = 1'b0; m_event = 1'b0; m_run = 0;
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
    end else begin
      m_s = hist[SYNC-1];
      hist.push_front(pad);
      void'(hist.pop_back());
      m_pulse = 1'b0;
      m_hit   = 1'b0;
      if (!enable) begin
        m_run = 0;
      end else if (m_s != m_value) begin
        m_run++;
        if (m_run >= int'(filter_len) + 1) begin
          m_pulse = 1'b1;
          m_value = m_s;
          m_run   = 0;
          m_hit   = (edge_sel == BOTH) || (edge_sel == RISE && m_s) || (edge_sel == FALL && !m_s);
        end
      end else begin
        m_run = 0;
      end
      if (m_hit)          m_event = 1'b1;
      else if (event_clr) m_event = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("model_value", value, m_value);
      check_eq("model_pulse", pulse, m_pulse);
      check_eq("model_event", event_flag, m_event);
    end
  end

  int cyc;
  int hold;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_value", value, 0);
    check_eq("reset_pulse", pulse, 0);
    check_eq("reset_event", event_flag, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (4) @(negedge clk);

    // Clean rise: N=3, BOTH
    filter_len = 3; edge_sel = BOTH; pad = 1'b1; cyc = 0;
    while (cyc < 20) begin
      @(negedge clk); cyc++;
      if (value) break;
    end
    check_eq("rise_latency", cyc, SYNC + 3 + 1);
    check_eq("rise_pulse", pulse, 1);
    check_eq("rise_event", event_flag, 1);
    @(negedge clk);
    check_eq("rise_pulse_one_cycle", pulse, 0);
    event_clr = 1'b1;
    @(negedge clk);
    event_clr = 1'b0;
    check_eq("clear_event", event_flag, 0);

    // Glitch: N=4, return low then a 3-cycle high pulse
    filter_len = 4; pad = 1'b0;
    repeat (12) @(negedge clk);
    event_clr = 1'b1; @(negedge clk); event_clr = 1'b0;
    pad = 1'b1; repeat (3) @(negedge clk); pad = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("glitch_value", value, 0);
    check_eq("glitch_event", event_flag, 0);

    // Enable drop mid-qualification, then re-enable with N=2
    pad = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("disabled_hold", value, 0);
    enable = 1'b1; filter_len = 2; cyc = 0;
    while (cyc < 20) begin
      @(negedge clk); cyc++;
      if (value) break;
    end
    check_eq("reenable_latency", cyc, 3);

    // Randomized phase
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        pad  = 1'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      if ($urandom_range(0, 19) == 0) filter_len = CW'($urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0) edge_sel = edge_sel_e'($urandom_range(0, 3));
      enable    = ($urandom_range(0, 19) != 0);
      event_clr = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end

    // Asynchronous reset mid-qualification
    enable = 1'b1; event_clr = 1'b0; edge_sel = BOTH; filter_len = 0;
    pad = 1'b0; repeat (6) @(negedge clk);
    pad = 1'b1; repeat (6) @(negedge clk);
    check_eq("pre_reset_value", value, 1);
    check_eq("pre_reset_event", event_flag, 1);
    filter_len = 10; pad = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset_value", value, 0);
    check_eq("async_reset_pulse", pulse, 0);
    check_eq("async_reset_event", event_flag, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pad = 1'($urandom);
      filter_len = CW'($urandom_range(0, 2));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
